// File: rtl/tdm_demux.sv
// Serial-to-parallel TDM demultiplexer: one bit per accepted cycle fills slot 0..N-1, then the word moves to dout.
// Optional frame realign input 'sync' is built in when TDM_SYNC_EN is defined.
//
// state | meaning
// IDLE  | slot = 0, no word buffered
// FILL  | frame partly assembled, or a word buffered while assembling
// FULL  | word buffered and slot = N-1 (last bit waits for the consumer)
module tdm_demux #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef TDM_SYNC_EN
  input  logic                 sync,
`endif
  input  logic                 din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [$clog2(N)-1:0] slot,
  output logic [N-1:0]         dout,
  output logic                 dout_valid,
  input  logic                 dout_ready
);

  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  asm_q, asm_nxt, dout_nxt;
  logic [SW-1:0] slot_nxt, base;
  logic          dv_nxt, live, sync_i, stall, accept, consume;

`ifdef TDM_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  // A realign sends the incoming bit to slot 0, so it can never overwrite the buffered word.
  assign stall     = (state == FULL) && !dout_ready && !sync_i;
  assign din_ready = live && !stall;
  assign accept    = din_valid && din_ready;
  assign consume   = dout_valid && dout_ready;

  always_comb begin
    asm_nxt  = asm_q;
    slot_nxt = slot;
    dout_nxt = dout;
    dv_nxt   = dout_valid && !consume;
    base     = sync_i ? '0 : slot;
    if (sync_i) slot_nxt = '0;
    if (accept) begin
      asm_nxt[base] = din;
      if (base == LAST) begin
        slot_nxt = '0;
        dout_nxt = asm_nxt;
        dv_nxt   = 1'b1;
      end else begin
        slot_nxt = base + SW'(1);
      end
    end
    if (!dv_nxt && slot_nxt == '0)
      state_nxt = IDLE;
    else if (dv_nxt && slot_nxt == LAST)
      state_nxt = FULL;
    else
      state_nxt = FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      live       <= 1'b0;
      slot       <= '0;
      asm_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      live       <= 1'b1;
      slot       <= slot_nxt;
      asm_q      <= asm_nxt;
      dout       <= dout_nxt;
      dout_valid <= dv_nxt;
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N=8): vector table for framing and gaps, hand sequences for stall, reset and sync.
module tb_tdm_demux;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sync;
  logic         din, din_valid, din_ready;
  logic [2:0]   slot;
  logic [N-1:0] dout;
  logic         dout_valid, dout_ready;

  int n_checks = 0;
  int n_err    = 0;

  tdm_demux #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef TDM_SYNC_EN
    .sync(sync),
`endif
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .slot(slot), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       din, vld, rdy;
    logic       e_din_ready;
    logic [2:0] e_slot;
    logic       e_dv;
    logic [7:0] e_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic d, v, r, er, input logic [2:0] es, input logic edv, input logic [7:0] ed);
    vec_t t;
    t.din = d; t.vld = v; t.rdy = r; t.e_din_ready = er; t.e_slot = es; t.e_dv = edv; t.e_dout = ed;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] w, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      din = w[k];
      din_valid = 1'b1;
      cyc();
    end
    din_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; sync = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    #1;
    chk("rst_slot", slot, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dv", dout_valid, 0);
    chk("rst_din_ready", din_ready, 0);
    #11 rst_n = 1'b1;
    #1 chk("rel_din_ready_pre_edge", din_ready, 0);
    cyc();
    chk("rel_din_ready", din_ready, 1);

    // gap-free frame 0,0,1,1,0,1,0,1 -> 8'hAC, one valid cycle
    add(0,1,1, 1,3'd1,0,8'h00);
    add(0,1,1, 1,3'd2,0,8'h00);
    add(1,1,1, 1,3'd3,0,8'h00);
    add(1,1,1, 1,3'd4,0,8'h00);
    add(0,1,1, 1,3'd5,0,8'h00);
    add(1,1,1, 1,3'd6,0,8'h00);
    add(0,1,1, 1,3'd7,0,8'h00);
    add(1,1,1, 1,3'd0,1,8'hAC);
    add(1,0,1, 1,3'd0,0,8'hAC);
    // same frame with din_valid toggling; din junk on idle cycles
    add(0,1,1, 1,3'd1,0,8'hAC);
    add(1,0,1, 1,3'd1,0,8'hAC);
    add(0,1,1, 1,3'd2,0,8'hAC);
    add(1,0,1, 1,3'd2,0,8'hAC);
    add(1,1,1, 1,3'd3,0,8'hAC);
    add(0,0,1, 1,3'd3,0,8'hAC);
    add(1,1,1, 1,3'd4,0,8'hAC);
    add(0,0,1, 1,3'd4,0,8'hAC);
    add(0,1,1, 1,3'd5,0,8'hAC);
    add(1,0,1, 1,3'd5,0,8'hAC);
    add(1,1,1, 1,3'd6,0,8'hAC);
    add(1,0,1, 1,3'd6,0,8'hAC);
    add(0,1,1, 1,3'd7,0,8'hAC);
    add(0,0,1, 1,3'd7,0,8'hAC);
    add(1,1,1, 1,3'd0,1,8'hAC);
    add(0,0,1, 1,3'd0,0,8'hAC);

    foreach (vecs[i]) begin
      din = vecs[i].din; din_valid = vecs[i].vld; dout_ready = vecs[i].rdy;
      #1 chk($sformatf("v%0d_din_ready", i), din_ready, vecs[i].e_din_ready);
      cyc();
      chk($sformatf("v%0d_slot", i), slot, vecs[i].e_slot);
      chk($sformatf("v%0d_dv", i), dout_valid, vecs[i].e_dv);
      chk($sformatf("v%0d_dout", i), dout, vecs[i].e_dout);
    end
    din_valid = 1'b0;

    // back-pressure: two words back to back with consumer stalled
    dout_ready = 1'b0;
    send_bits(8'h96, 0, 7);
    chk("bp_w1_dv", dout_valid, 1);
    chk("bp_w1_dout", dout, 8'h96);
    send_bits(8'h5A, 0, 6);
    chk("bp_slot7", slot, 7);
    chk("bp_w1_held", dout, 8'h96);
    din = 1'b0; din_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_stall_din_ready", din_ready, 0);
      cyc();
      chk("bp_stall_slot", slot, 7);
      chk("bp_stall_dout", dout, 8'h96);
      chk("bp_stall_dv", dout_valid, 1);
    end
    dout_ready = 1'b1;
    #1 chk("bp_release_din_ready", din_ready, 1);
    cyc();
    chk("bp_w2_dv", dout_valid, 1);
    chk("bp_w2_dout", dout, 8'h5A);
    chk("bp_w2_slot", slot, 0);
    din_valid = 1'b0;
    cyc();
    chk("bp_drain_dv", dout_valid, 0);

    // asynchronous reset at slot 5 with a word buffered
    dout_ready = 1'b0;
    send_bits(8'h96, 0, 7);
    send_bits(8'hFF, 0, 4);
    chk("ar_pre_slot", slot, 5);
    chk("ar_pre_dv", dout_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_slot", slot, 0);
    chk("ar_dout", dout, 0);
    chk("ar_dv", dout_valid, 0);
    chk("ar_din_ready", din_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    dout_ready = 1'b1;
    send_bits(8'hC3, 0, 7);
    chk("ar_next_dv", dout_valid, 1);
    chk("ar_next_dout", dout, 8'hC3);
    cyc();
    chk("ar_next_drain", dout_valid, 0);

`ifdef TDM_SYNC_EN
    dout_ready = 1'b0;
    send_bits(8'h96, 0, 7);
    send_bits(8'h00, 0, 2);
    chk("sy_pre_slot", slot, 3);
    sync = 1'b1; din = 1'b1; din_valid = 1'b1;
    cyc();
    sync = 1'b0; din_valid = 1'b0;
    chk("sy_slot", slot, 1);
    chk("sy_buf_dout", dout, 8'h96);
    chk("sy_buf_dv", dout_valid, 1);
    dout_ready = 1'b1;
    send_bits(8'h00, 1, 7);
    chk("sy_word_dv", dout_valid, 1);
    chk("sy_word_dout", dout, 8'h01);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
